// File: rtl/rc5_dut.sv
// RC5-32/12/16 iterative engine: byte-wide key RAM, on-chip key expansion into
// the S table, then one 64-bit block enciphered or deciphered per start request.

// Single-port storage with combinational read, used for the key, L and S arrays.
module rc5_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] ram [DEPTH];

    // Write port; NOTE: the array has no reset so the key survives rst and
    // the storage can map onto plain RAM without a clear sequence.
    always_ff @(posedge clk) begin
        if (wen) ram[addr] <= wdata;
    end

    assign rdata = ram[addr];
endmodule

module rc5_dut #(
    parameter int           W  = 32,
    parameter int           C  = 4,
    parameter int           B  = 16,
    parameter int           R  = 12,
    parameter logic [W-1:0] QW = 32'h9e3779b9,
    parameter logic [W-1:0] PW = 32'hb7e15163
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStartCipher,
    input  logic                 iStartDecipher,
    input  logic [7:0]           iKey_sub_i,
    input  logic [$clog2(B)-1:0] iKey_address,
    input  logic                 iWen,
    input  logic [W-1:0]         iA,
    input  logic [W-1:0]         iB,
    input  logic [W-1:0]         iA_cipher,
    input  logic [W-1:0]         iB_cipher,
    output logic [W-1:0]         oA_cipher,
    output logic [W-1:0]         oB_cipher,
    output logic [W-1:0]         oA_decipher,
    output logic [W-1:0]         oB_decipher,
    output logic                 oDoneCipher,
    output logic                 oDoneDecipher
);
    localparam int T    = 2 * R + 2;
    localparam int MIXN = 3 * ((T > C) ? T : C);
    localparam int RW   = $clog2(W);
    localparam int KAW  = $clog2(B);
    localparam int LAW  = $clog2(C);
    localparam int SAW  = $clog2(T);
    localparam int CW   = $clog2(MIXN);

    localparam logic [CW-1:0]  KEY_LAST = CW'(B - 1);
    localparam logic [CW-1:0]  TAB_LAST = CW'(T - 1);
    localparam logic [CW-1:0]  MIX_LAST = CW'(MIXN - 1);
    localparam logic [SAW-1:0] S_TOP    = SAW'(T - 1);
    localparam logic [LAW-1:0] L_TOP    = LAW'(C - 1);

    typedef enum logic [2:0] {IDLE, LOAD_L, INIT_S, MIX, CRYPT, DONE} stateType;

    stateType state, nextState;

    logic [CW-1:0]  cnt;
    logic           modeDec;
    logic [W-1:0]   regA, regB;
    logic [SAW-1:0] sIdx;
    logic [LAW-1:0] lIdx;
    logic [W-1:0]   sVal;
    logic [W-9:0]   lWord;

    logic           kWen, lWen, sWen;
    logic [KAW-1:0] kAddr;
    logic [LAW-1:0] lAddr;
    logic [SAW-1:0] sAddr, cryptIdx;
    logic [7:0]     kRdata;
    logic [W-1:0]   lWdata, lRdata, sWdata, sRdata;
    logic [W-1:0]   mixA, mixB, cryptA, cryptB;
    logic [RW-1:0]  mixAmt;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] n);
        logic [RW-1:0] m;
        m = -n;
        return (x << n) | (x >> m);
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [RW-1:0] n);
        logic [RW-1:0] m;
        m = -n;
        return (x >> n) | (x << m);
    endfunction

    rc5_ram #(.DEPTH(B), .WIDTH(8)) key_RAM (
        .clk(clk), .wen(kWen), .addr(kAddr), .wdata(iKey_sub_i), .rdata(kRdata)
    );

    rc5_ram #(.DEPTH(C), .WIDTH(W)) L_RAM (
        .clk(clk), .wen(lWen), .addr(lAddr), .wdata(lWdata), .rdata(lRdata)
    );

    rc5_ram #(.DEPTH(T), .WIDTH(W)) S_RAM (
        .clk(clk), .wen(sWen), .addr(sAddr), .wdata(sWdata), .rdata(sRdata)
    );

    // One key-schedule mix iteration per cycle: S[i] and L[j] are updated together.
    assign mixA   = rotl(sRdata + regA + regB, RW'(3));
    assign mixAmt = mixA[RW-1:0] + regB[RW-1:0];
    assign mixB   = rotl(lRdata + mixA + regB, mixAmt);

    // Cipher walks the S table upwards, decipher walks it downwards.
    assign cryptIdx = modeDec ? (S_TOP - cnt[SAW-1:0]) : cnt[SAW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state decode; the DONE exit follows the start level of the latched mode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iStartCipher || iStartDecipher) nextState = LOAD_L;
            LOAD_L:  if (cnt == KEY_LAST) nextState = INIT_S;
            INIT_S:  if (cnt == TAB_LAST) nextState = MIX;
            MIX:     if (cnt == MIX_LAST) nextState = CRYPT;
            CRYPT:   if (cnt == TAB_LAST) nextState = DONE;
            DONE:    if (!(modeDec ? iStartDecipher : iStartCipher)) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // RAM port steering; NOTE: every output gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        kWen   = 1'b0;
        kAddr  = iKey_address;
        lWen   = 1'b0;
        lAddr  = lIdx;
        lWdata = mixB;
        sWen   = 1'b0;
        sAddr  = sIdx;
        sWdata = mixA;
        case (state)
            IDLE: kWen = iWen;
            LOAD_L: begin
                kAddr  = cnt[KAW-1:0];
                lAddr  = cnt[LAW+1:2];
                lWdata = {kRdata, lWord};
                lWen   = (cnt[1:0] == 2'b11);  // fourth byte completes an L word
            end
            INIT_S: begin
                sAddr  = cnt[SAW-1:0];
                sWdata = sVal;
                sWen   = 1'b1;
            end
            MIX: begin
                sWen = 1'b1;
                lWen = 1'b1;
            end
            CRYPT: sAddr = cryptIdx;
            default: ;
        endcase
    end

    // One half-round per cycle; indices 0 and 1 are the whitening steps.
    always_comb begin
        cryptA = regA;
        cryptB = regB;
        if (!modeDec) begin
            if (cryptIdx[SAW-1:1] == '0) begin
                if (!cryptIdx[0]) cryptA = regA + sRdata;
                else              cryptB = regB + sRdata;
            end else if (!cryptIdx[0]) begin
                cryptA = rotl(regA ^ regB, regB[RW-1:0]) + sRdata;
            end else begin
                cryptB = rotl(regB ^ regA, regA[RW-1:0]) + sRdata;
            end
        end else begin
            if (cryptIdx[SAW-1:1] == '0) begin
                if (!cryptIdx[0]) cryptA = regA - sRdata;
                else              cryptB = regB - sRdata;
            end else if (!cryptIdx[0]) begin
                cryptA = rotr(regA - sRdata, regB[RW-1:0]) ^ regB;
            end else begin
                cryptB = rotr(regB - sRdata, regA[RW-1:0]) ^ regA;
            end
        end
    end

    // Datapath registers and result outputs; NOTE: non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            modeDec       <= 1'b0;
            regA          <= '0;
            regB          <= '0;
            sIdx          <= '0;
            lIdx          <= '0;
            sVal          <= PW;
            lWord         <= '0;
            oA_cipher     <= '0;
            oB_cipher     <= '0;
            oA_decipher   <= '0;
            oB_decipher   <= '0;
            oDoneCipher   <= 1'b0;
            oDoneDecipher <= 1'b0;
        end else begin
            cnt <= (nextState != state) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    modeDec <= !iStartCipher;
                    sVal    <= PW;
                end
                LOAD_L: lWord <= {kRdata, lWord[W-9:8]};
                INIT_S: begin
                    sVal <= sVal + QW;
                    regA <= '0;
                    regB <= '0;
                    sIdx <= '0;
                    lIdx <= '0;
                end
                MIX: begin
                    if (nextState == CRYPT) begin
                        regA <= modeDec ? iA_cipher : iA;
                        regB <= modeDec ? iB_cipher : iB;
                    end else begin
                        regA <= mixA;
                        regB <= mixB;
                    end
                    sIdx <= (sIdx == S_TOP) ? '0 : sIdx + 1'b1;
                    lIdx <= (lIdx == L_TOP) ? '0 : lIdx + 1'b1;
                end
                CRYPT: begin
                    regA <= cryptA;
                    regB <= cryptB;
                    if (nextState == DONE) begin
                        if (modeDec) begin
                            oA_decipher   <= cryptA;
                            oB_decipher   <= cryptB;
                            oDoneDecipher <= 1'b1;
                        end else begin
                            oA_cipher   <= cryptA;
                            oB_cipher   <= cryptB;
                            oDoneCipher <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (nextState == IDLE) begin
                        oDoneCipher   <= 1'b0;
                        oDoneDecipher <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_dut.sv
// Self-checking bench for rc5_dut: directed vectors plus random keys and blocks
// compared against a loop-based RC5-32/12/16 reference model.
module tb_rc5_dut;
    localparam logic [31:0] PW = 32'hb7e15163;
    localparam logic [31:0] QW = 32'h9e3779b9;

    logic        clk = 1'b0;
    logic        rst;
    logic        iStartCipher, iStartDecipher;
    logic [7:0]  iKey_sub_i;
    logic [3:0]  iKey_address;
    logic        iWen;
    logic [31:0] iA, iB, iA_cipher, iB_cipher;
    logic [31:0] oA_cipher, oB_cipher, oA_decipher, oB_decipher;
    logic        oDoneCipher, oDoneDecipher;

    int checks = 0;
    int failures = 0;

    logic [7:0]  keyBytes [16];
    logic [31:0] mS [26];

    rc5_dut dut (
        .clk(clk), .rst(rst),
        .iStartCipher(iStartCipher), .iStartDecipher(iStartDecipher),
        .iKey_sub_i(iKey_sub_i), .iKey_address(iKey_address), .iWen(iWen),
        .iA(iA), .iB(iB), .iA_cipher(iA_cipher), .iB_cipher(iB_cipher),
        .oA_cipher(oA_cipher), .oB_cipher(oB_cipher),
        .oA_decipher(oA_decipher), .oB_decipher(oB_decipher),
        .oDoneCipher(oDoneCipher), .oDoneDecipher(oDoneDecipher)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] x, input logic [31:0] n);
        int k = int'(n % 32);
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input logic [31:0] n);
        int k = int'(n % 32);
        if (k == 0) return x;
        return (x >> k) | (x << (32 - k));
    endfunction

    task automatic modelSchedule();
        logic [31:0] lw [4];
        logic [31:0] a, b;
        int i, j;
        for (int q = 0; q < 4; q++)
            lw[q] = {keyBytes[4*q+3], keyBytes[4*q+2], keyBytes[4*q+1], keyBytes[4*q]};
        mS[0] = PW;
        for (int q = 1; q < 26; q++) mS[q] = mS[q-1] + QW;
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            a = rol(mS[i] + a + b, 3);
            mS[i] = a;
            b = rol(lw[j] + a + b, a + b);
            lw[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic modelEncrypt(input logic [31:0] pa, pb, output logic [31:0] ca, cb);
        ca = pa + mS[0];
        cb = pb + mS[1];
        for (int r = 1; r <= 12; r++) begin
            ca = rol(ca ^ cb, cb) + mS[2*r];
            cb = rol(cb ^ ca, ca) + mS[2*r+1];
        end
    endtask

    task automatic modelDecrypt(input logic [31:0] ca, cb, output logic [31:0] pa, pb);
        pa = ca;
        pb = cb;
        for (int r = 12; r >= 1; r--) begin
            pb = ror(pb - mS[2*r+1], pa) ^ pa;
            pa = ror(pa - mS[2*r], pb) ^ pb;
        end
        pb = pb - mS[1];
        pa = pa - mS[0];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic loadKey();
        for (int q = 0; q < 16; q++) begin
            @(negedge clk);
            iWen = 1'b1;
            iKey_address = 4'(q);
            iKey_sub_i = keyBytes[q];
        end
        @(negedge clk);
        iWen = 1'b0;
    endtask

    // Raises one start, optionally scribbles on the key port while busy, waits for done.
    // The start is left high; releaseStarts() drops it.
    task automatic runOp(input bit dec, input logic [31:0] a, b, input bit junk,
                         output logic [31:0] ra, rb);
        int waited = 0;
        @(negedge clk);
        if (dec) begin
            iA_cipher = a; iB_cipher = b; iStartDecipher = 1'b1;
        end else begin
            iA = a; iB = b; iStartCipher = 1'b1;
        end
        if (junk) begin
            repeat (20) begin
                @(negedge clk);
                iWen = 1'b1;
                iKey_address = 4'($urandom);
                iKey_sub_i = 8'($urandom);
                waited++;
            end
            iWen = 1'b0;
        end
        while (!(dec ? oDoneDecipher : oDoneCipher) && waited < 1900) begin
            @(negedge clk);
            waited++;
        end
        check(dec ? "decipher_done_in_time" : "cipher_done_in_time",
              {31'b0, dec ? oDoneDecipher : oDoneCipher}, 32'd1);
        ra = dec ? oA_decipher : oA_cipher;
        rb = dec ? oB_decipher : oB_cipher;
    endtask

    task automatic releaseStarts();
        @(negedge clk);
        iStartCipher = 1'b0;
        iStartDecipher = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, ea, eb, pa, pb;
        int lowCycles;
        bit sawDec;

        rst = 1'b1;
        iStartCipher = 1'b0; iStartDecipher = 1'b0;
        iKey_sub_i = '0; iKey_address = '0; iWen = 1'b0;
        iA = '0; iB = '0; iA_cipher = '0; iB_cipher = '0;

        // Reset state
        @(negedge clk);
        check("rst_oA_cipher", oA_cipher, 32'h0);
        check("rst_oB_cipher", oB_cipher, 32'h0);
        check("rst_oA_decipher", oA_decipher, 32'h0);
        check("rst_oB_decipher", oB_decipher, 32'h0);
        check("rst_done_cipher", {31'b0, oDoneCipher}, 32'd0);
        check("rst_done_decipher", {31'b0, oDoneDecipher}, 32'd0);
        rst = 1'b0;

        // Zero key, zero block
        for (int q = 0; q < 16; q++) keyBytes[q] = 8'h00;
        loadKey();
        modelSchedule();
        runOp(1'b0, 32'h0, 32'h0, 1'b0, ra, rb);
        check("zero_key_A", ra, 32'heedba521);
        check("zero_key_B", rb, 32'h6d8f4b15);
        check("zero_key_no_dec_done", {31'b0, oDoneDecipher}, 32'd0);

        // Start held high: done stays up, no rerun
        lowCycles = 0;
        repeat (300) begin
            @(negedge clk);
            if (!oDoneCipher) lowCycles++;
        end
        check("hold_no_retrigger", lowCycles, 0);
        check("hold_A", oA_cipher, 32'heedba521);

        // Start release clears done the next cycle, data kept
        @(negedge clk);
        iStartCipher = 1'b0;
        @(negedge clk);
        check("release_done_low", {31'b0, oDoneCipher}, 32'd0);
        check("release_A_kept", oA_cipher, 32'heedba521);
        check("release_B_kept", oB_cipher, 32'h6d8f4b15);

        // Reassert gives the same result
        runOp(1'b0, 32'h0, 32'h0, 1'b0, ra, rb);
        check("reassert_A", ra, 32'heedba521);
        check("reassert_B", rb, 32'h6d8f4b15);
        releaseStarts();

        // Published test key
        keyBytes = '{8'h91, 8'h5F, 8'h46, 8'h19, 8'hBE, 8'h41, 8'hB2, 8'h51,
                     8'h63, 8'h55, 8'hA5, 8'h01, 8'h10, 8'hA9, 8'hCE, 8'h91};
        loadKey();
        modelSchedule();
        runOp(1'b0, 32'heedba521, 32'h6d8f4b15, 1'b0, ra, rb);
        check("test_key_enc_A", ra, 32'hac13c0f7);
        check("test_key_enc_B", rb, 32'h52892b5b);
        releaseStarts();
        runOp(1'b1, 32'hac13c0f7, 32'h52892b5b, 1'b0, ra, rb);
        check("test_key_dec_A", ra, 32'heedba521);
        check("test_key_dec_B", rb, 32'h6d8f4b15);
        releaseStarts();

        // Both starts high: cipher wins
        @(negedge clk);
        iA = 32'h01234567; iB = 32'h89abcdef;
        iA_cipher = 32'hdeadbeef; iB_cipher = 32'hcafef00d;
        iStartCipher = 1'b1; iStartDecipher = 1'b1;
        sawDec = 1'b0;
        for (int n = 0; n < 1900 && !oDoneCipher; n++) begin
            @(negedge clk);
            if (oDoneDecipher) sawDec = 1'b1;
        end
        modelEncrypt(32'h01234567, 32'h89abcdef, ea, eb);
        check("both_cipher_done", {31'b0, oDoneCipher}, 32'd1);
        check("both_cipher_A", oA_cipher, ea);
        check("both_cipher_B", oB_cipher, eb);
        check("both_no_dec_done", {31'b0, sawDec}, 32'd0);
        check("both_dec_A_kept", oA_decipher, 32'heedba521);
        releaseStarts();

        // Random keys and blocks against the model; odd passes write the key port while busy
        for (int n = 0; n < 6; n++) begin
            for (int q = 0; q < 16; q++) keyBytes[q] = 8'($urandom);
            loadKey();
            modelSchedule();
            pa = $urandom; pb = $urandom;
            modelEncrypt(pa, pb, ea, eb);
            runOp(1'b0, pa, pb, (n % 2) == 1, ra, rb);
            check("rand_enc_A", ra, ea);
            check("rand_enc_B", rb, eb);
            releaseStarts();
            pa = $urandom; pb = $urandom;
            modelDecrypt(pa, pb, ea, eb);
            runOp(1'b1, pa, pb, 1'b0, ra, rb);
            check("rand_dec_A", ra, ea);
            check("rand_dec_B", rb, eb);
            releaseStarts();
        end

        // Mid-operation reset aborts and clears outputs; key RAM survives
        @(negedge clk);
        iA = 32'h13579bdf; iB = 32'h2468ace0;
        iStartCipher = 1'b1;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        iStartCipher = 1'b0;
        @(negedge clk);
        check("midrst_oA_cipher", oA_cipher, 32'h0);
        check("midrst_oB_cipher", oB_cipher, 32'h0);
        check("midrst_oA_decipher", oA_decipher, 32'h0);
        check("midrst_oB_decipher", oB_decipher, 32'h0);
        check("midrst_done_cipher", {31'b0, oDoneCipher}, 32'd0);
        check("midrst_done_decipher", {31'b0, oDoneDecipher}, 32'd0);
        rst = 1'b0;
        lowCycles = 0;
        repeat (200) begin
            @(negedge clk);
            if (oDoneCipher || oDoneDecipher) lowCycles++;
        end
        check("midrst_stays_idle", lowCycles, 0);
        modelEncrypt(32'h13579bdf, 32'h2468ace0, ea, eb);
        runOp(1'b0, 32'h13579bdf, 32'h2468ace0, 1'b0, ra, rb);
        check("post_rst_enc_A", ra, ea);
        check("post_rst_enc_B", rb, eb);
        releaseStarts();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
